// File: rtl/jpeg_fdct_pkg.sv
// Shared constants for the sequential 8x8 forward DCT: default precisions,
// the integer cosine table K[k][n] and the controller state encoding.
package jpeg_fdct_pkg;

    localparam int CONST_BITS_DEF = 13;
    localparam int PASS1_BITS_DEF = 2;
    localparam int COEF_W_DEF     = 12;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ROW  = 2'd1,
        S_COL  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // K[k][n] = round(2^13 * c(k)/2 * cos((2n+1)k*pi/16)), row-major by k
    localparam int K_TAB [64] = '{
        2896,  2896,  2896,  2896,  2896,  2896,  2896,  2896,
        4017,  3406,  2276,   799,  -799, -2276, -3406, -4017,
        3784,  1567, -1567, -3784, -3784, -1567,  1567,  3784,
        3406,  -799, -4017, -2276,  2276,  4017,   799, -3406,
        2896, -2896, -2896,  2896,  2896, -2896, -2896,  2896,
        2276, -4017,   799,  3406, -3406,  -799,  4017, -2276,
        1567, -3784,  3784, -1567, -1567,  3784, -3784,  1567,
         799, -2276,  3406, -4017,  4017, -3406,  2276,  -799
    };

    function automatic logic signed [15:0] k_coef(input int k, input int n);
        return 16'(K_TAB[k*8 + n]);
    endfunction

endpackage

// File: rtl/jpeg_fdct_2d_seq_1d.sv
// Combinational 8-point forward DCT: raw 32-bit dot products of the input
// vector with each cosine row; the caller owns rounding and scaling.
module jpeg_fdct_1d
    import jpeg_fdct_pkg::*;
(
    input  logic [127:0] i_x,
    output logic [255:0] o_sum
);

    function automatic logic signed [31:0] dot8(input logic [127:0] x, input int k);
        logic signed [31:0] acc;
        acc = '0;
        for (int n = 0; n < 8; n++) begin
            acc = acc + 32'($signed(x[n*16 +: 16])) * 32'(k_coef(k, n));
        end
        return acc;
    endfunction

    always_comb begin
        o_sum = '0;
        for (int k = 0; k < 8; k++) begin
            o_sum[k*32 +: 32] = dot8(i_x, k);
        end
    end

endmodule

// File: rtl/jpeg_fdct_2d_seq.sv
// Sequential 8x8 forward DCT: load 64 pixels, 8 row passes, 8 column passes
// through one shared 1D unit, then stream 64 coefficients in raster order.
module jpeg_fdct_2d_seq
    import jpeg_fdct_pkg::*;
#(
    parameter int CONST_BITS  = CONST_BITS_DEF,
    parameter int PASS1_BITS  = PASS1_BITS_DEF,
    parameter int COEF_W      = COEF_W_DEF,
    parameter bit LEVEL_SHIFT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_coef,
    output logic [5:0]        out_index,
    output logic              out_last,
    output logic              busy
);

    localparam int ROW_SH = CONST_BITS - PASS1_BITS;
    localparam int COL_SH = CONST_BITS + PASS1_BITS;
    localparam logic signed [31:0] ROW_RND  = 32'sd1 <<< (ROW_SH - 1);
    localparam logic signed [31:0] COL_RND  = 32'sd1 <<< (COL_SH - 1);
    localparam logic signed [31:0] COEF_MAX = (32'sd1 <<< (COEF_W - 1)) - 32'sd1;
    localparam logic signed [31:0] COEF_MIN = -(32'sd1 <<< (COEF_W - 1));

    state_t r_state;
    state_t w_next;

    logic [5:0] r_cnt;
    logic [2:0] r_pass;

    logic signed [8:0]        r_pix  [64];
    logic signed [15:0]       r_tbuf [64];
    logic signed [COEF_W-1:0] r_coef [64];

    logic              r_out_valid;
    logic [5:0]        r_out_index;
    logic [COEF_W-1:0] r_out_coef;

    logic                     w_in_fire;
    logic                     w_out_fire;
    logic signed [8:0]        w_pix_lvl;
    logic [127:0]             w_x;
    logic [255:0]             w_sum_flat;
    logic signed [15:0]       w_row_res [8];
    logic signed [COEF_W-1:0] w_col_res [8];

    assign in_ready   = (r_state == S_LOAD);
    assign busy       = (r_state != S_LOAD);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign out_coef  = r_out_coef;
    assign out_index = r_out_index;
    assign out_last  = r_out_valid && (r_out_index == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: if (w_in_fire && r_cnt == 6'd63) w_next = S_ROW;
            S_ROW:  if (r_pass == 3'd7) w_next = S_COL;
            S_COL:  if (r_pass == 3'd7) w_next = S_OUT;
            S_OUT:  if (w_out_fire && r_out_index == 6'd63) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_comb begin
        if (LEVEL_SHIFT) begin
            w_pix_lvl = $signed({1'b0, in_pixel}) - 9'sd128;
        end else begin
            w_pix_lvl = 9'($signed(in_pixel));
        end
    end

    // Row pass reads pixel row r_pass; column pass reads tbuf column r_pass.
    always_comb begin
        w_x = '0;
        for (int n = 0; n < 8; n++) begin
            if (r_state == S_COL) begin
                w_x[n*16 +: 16] = r_tbuf[{3'(n), r_pass}];
            end else begin
                w_x[n*16 +: 16] = 16'(r_pix[{r_pass, 3'(n)}]);
            end
        end
    end

    jpeg_fdct_1d u_fdct_1d (
        .i_x   (w_x),
        .o_sum (w_sum_flat)
    );

    always_comb begin
        logic signed [31:0] w_s;
        logic signed [31:0] w_sh;
        for (int k = 0; k < 8; k++) begin
            w_s          = $signed(w_sum_flat[k*32 +: 32]);
            w_row_res[k] = 16'((w_s + ROW_RND) >>> ROW_SH);
            w_sh         = (w_s + COL_RND) >>> COL_SH;
            if (w_sh > COEF_MAX) begin
                w_col_res[k] = COEF_W'(COEF_MAX);
            end else if (w_sh < COEF_MIN) begin
                w_col_res[k] = COEF_W'(COEF_MIN);
            end else begin
                w_col_res[k] = COEF_W'(w_sh);
            end
        end
    end

    // Storage arrays carry no reset; stale contents are never read before rewrite.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && w_in_fire) begin
            r_pix[r_cnt] <= w_pix_lvl;
        end
        if (r_state == S_ROW) begin
            for (int k = 0; k < 8; k++) begin
                r_tbuf[{r_pass, 3'(k)}] <= w_row_res[k];
            end
        end
        if (r_state == S_COL) begin
            for (int k = 0; k < 8; k++) begin
                r_coef[{3'(k), r_pass}] <= w_col_res[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_pass      <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_coef  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_pass <= '0;
                    if (w_in_fire) r_cnt <= r_cnt + 6'd1;
                end
                S_ROW, S_COL: begin
                    r_pass <= r_pass + 3'd1;
                end
                S_OUT: begin
                    // First S_OUT cycle primes the output register with coef[0].
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_index <= '0;
                        r_out_coef  <= r_coef[0];
                    end else if (w_out_fire) begin
                        if (r_out_index == 6'd63) begin
                            r_out_valid <= 1'b0;
                            r_out_index <= '0;
                            r_out_coef  <= '0;
                        end else begin
                            r_out_index <= r_out_index + 6'd1;
                            r_out_coef  <= r_coef[r_out_index + 6'd1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_fdct_2d_seq.sv
// Self-checking bench for jpeg_fdct_2d_seq: flat, orientation and random
// blocks with stream backpressure, latency/period checks and mid-block resets.
module tb_jpeg_fdct_2d_seq;

    localparam int CB = 13;
    localparam int P1 = 2;
    localparam int CW = 12;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_coef;
    logic [5:0]    out_index;
    logic          out_last;
    logic          busy;

    jpeg_fdct_2d_seq #(
        .CONST_BITS  (CB),
        .PASS1_BITS  (P1),
        .COEF_W      (CW),
        .LEVEL_SHIFT (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] exp_v;
    int exp_idx = 0;

    int blk [64];
    int exp_blk [64];
    int kt [64];

    int acc_cyc = 0;
    int first_cyc = 0;
    bit lat_armed = 1'b0;
    bit ready_mode = 1'b0;
    bit stall30_pending = 1'b0;

    bit stall_prev = 1'b0;
    logic [CW-1:0] held_coef;
    logic [5:0] held_idx;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int round_r(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    task automatic build_k();
        real pi = 3.14159265358979;
        real ck;
        for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? 0.70710678118654752 : 1.0;
            for (int n = 0; n < 8; n++) begin
                kt[k*8+n] = round_r(8192.0 * ck / 2.0 * $cos(real'((2*n+1)*k) * pi / 16.0));
            end
        end
    endtask

    task automatic model_block();
        longint t [64];
        longint s;
        longint v;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                s = 0;
                for (int n = 0; n < 8; n++) s += longint'(blk[r*8+n] - 128) * longint'(kt[k*8+n]);
                t[r*8+k] = (s + (64'sd1 <<< (CB-P1-1))) >>> (CB-P1);
            end
        end
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) begin
                s = 0;
                for (int n = 0; n < 8; n++) s += t[n*8+c] * longint'(kt[k*8+n]);
                v = (s + (64'sd1 <<< (CB+P1-1))) >>> (CB+P1);
                if (v > 2047) v = 2047;
                if (v < -2048) v = -2048;
                exp_blk[k*8+c] = int'(v);
            end
        end
    endtask

    task automatic set_flat(input int pix, input int dc);
        for (int i = 0; i < 64; i++) begin
            blk[i] = pix;
            exp_blk[i] = 0;
        end
        exp_blk[0] = dc;
    endtask

    task automatic set_random();
        for (int i = 0; i < 64; i++) blk[i] = $urandom_range(0, 255);
        model_block();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_block(input int n_pix, input bit gaps);
        int i = 0;
        int budget;
        while (i < n_pix) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                in_valid = 1'b1;
                in_pixel = 8'(blk[i]);
                budget = 0;
                while (!in_ready && budget < 500) begin
                    @(posedge clk); #1;
                    budget++;
                end
                if (!in_ready) begin
                    check("in_ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
                if (i == 0) first_cyc = cyc;
                if (i == 63) begin
                    acc_cyc = cyc;
                    lat_armed = 1'b1;
                    for (int j = 0; j < 64; j++) exp_q.push_back(CW'(exp_blk[j]));
                end
                i++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int b = 0;
        while ((exp_q.size() != 0 || out_valid) && b < 3000) begin
            @(posedge clk); #1;
            b++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle_valid"}, int'(out_valid), 0);
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        exp_q.delete();
        exp_idx = 0;
        lat_armed = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!ready_mode) begin
                out_ready = 1'b1;
            end else if (stall30_pending && out_valid && out_index == 6'd30) begin
                out_ready = 1'b0;
                stall30_pending = 1'b0;
                repeat (10) begin
                    @(posedge clk); #1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && stall_prev) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_coef", int'(out_coef), int'(held_coef));
            check("hold_index", int'(out_index), int'(held_idx));
        end
        stall_prev = out_valid && !out_ready && !rst;
        held_coef = out_coef;
        held_idx = out_index;
        if (out_valid && !rst && lat_armed) begin
            check("latency", cyc - acc_cyc, 17);
            lat_armed = 1'b0;
        end
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", int'(out_index), -1);
            end else begin
                exp_v = exp_q.pop_front();
                check("coef", int'($signed(out_coef)), int'($signed(exp_v)));
                check("index", int'(out_index), exp_idx);
                check("last", int'(out_last), int'(exp_idx == 63));
                exp_idx = (exp_idx + 1) % 64;
            end
        end
    end

    // ---------------- main sequence ----------------
    int f1;
    int b;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        build_k();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_coef", int'(out_coef), 0);
        check("rst_busy", int'(busy), 0);

        set_flat(128, 0);
        send_block(64, 1'b0);
        check("busy_after_load", int'(busy), 1);
        check("in_ready_after_load", int'(in_ready), 0);
        wait_drain("flat128");

        set_flat(255, 1016);
        send_block(64, 1'b0);
        wait_drain("flat255");

        set_flat(0, -1024);
        send_block(64, 1'b0);
        wait_drain("flat0");

        for (int i = 0; i < 64; i++) blk[i] = (i < 8) ? 160 : 128;
        model_block();
        send_block(64, 1'b0);
        wait_drain("orient");

        for (int r = 0; r < 2; r++) begin
            set_random();
            ready_mode = 1'b1;
            stall30_pending = 1'b1;
            send_block(64, 1'b1);
            wait_drain("random");
            check("stall30_seen", int'(stall30_pending), 0);
            ready_mode = 1'b0;
        end

        set_flat(255, 1016);
        send_block(64, 1'b0);
        f1 = first_cyc;
        set_random();
        send_block(64, 1'b0);
        check("block_period_ge_144", int'((first_cyc - f1) >= 144), 1);
        wait_drain("b2b");

        set_random();
        send_block(40, 1'b0);
        pulse_rst("rst_load");
        set_flat(255, 1016);
        send_block(64, 1'b0);
        wait_drain("rst_load_b");

        set_random();
        send_block(64, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        check("busy_in_col", int'(busy), 1);
        pulse_rst("rst_col");
        set_flat(255, 1016);
        send_block(64, 1'b0);
        wait_drain("rst_col_b");

        for (int i = 0; i < 64; i++) blk[i] = (i < 8) ? 160 : 128;
        model_block();
        send_block(64, 1'b0);
        b = 0;
        while (!(out_valid && out_index == 6'd20) && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        check("reach_index20", int'(out_index), 20);
        pulse_rst("rst_out");
        set_flat(255, 1016);
        send_block(64, 1'b0);
        wait_drain("rst_out_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
